// File: rtl/mem_1r1w_ctrl_pkg.sv
// Shared types and defaults for the 1R1W memory controller.
// The optional zero-fill is enabled by the macro MEM_1R1W_CTRL_INIT_EN.
package mem_1r1w_ctrl_pkg;

  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_NREQ   = 2;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_1r1w_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr (wrapping). The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Extra bit in sum keeps the wrap correct when NREQ is not a power of two.
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_1r1w_ctrl.sv
// Controller for a 1R1W synchronous memory: round-robin read sharing, write
// forwarding and optional post-reset zero-fill (macro MEM_1R1W_CTRL_INIT_EN).
module mem_1r1w_ctrl
  import mem_1r1w_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREQ   = DEF_NREQ
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        rd_req_valid,
  input  logic [NREQ*ADDR_W-1:0] rd_req_addr,
  output logic [NREQ-1:0]        rd_req_ready,
  output logic [NREQ-1:0]        rd_resp_valid,
  output logic [DATA_W-1:0]      rd_resp_data,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic                   init_done,
  output logic [ADDR_W-1:0]      R0_addr,
  output logic                   R0_en,
  input  logic [DATA_W-1:0]      R0_data,
  output logic [ADDR_W-1:0]      W0_addr,
  output logic                   W0_en,
  output logic [DATA_W-1:0]      W0_data,
  output state_t                 dbg_state
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake semantics: a read from requester i transfers when
  // rd_req_valid[i] & rd_req_ready[i]; a write when wr_valid & wr_ready.
  // Requesters hold valid/addr until ready; ready may drop on lost arbitration.

  state_t             state, next_state;
  logic [PTR_W-1:0]   rr_ptr, rr_next;
  logic [NREQ-1:0]    grant, rd_hs;
  logic               wr_hs, fwd_hit, fwd_q;
  logic [DATA_W-1:0]  wdata_q;

`ifdef MEM_1R1W_CTRL_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] init_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          init_addr <= '0;
    else if (state == INIT) init_addr <= init_addr + 1'b1;
  end
`endif

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req   (rd_req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= BOOT;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    rd_req_ready = '0;
    wr_ready     = 1'b0;
    W0_en        = 1'b0;
    W0_addr      = '0;
    W0_data      = '0;
    case (state)
      BOOT: begin
`ifdef MEM_1R1W_CTRL_INIT_EN
        next_state = INIT;
`else
        next_state = RUN;
`endif
      end
      INIT: begin
`ifdef MEM_1R1W_CTRL_INIT_EN
        W0_en   = 1'b1;
        W0_addr = init_addr;
        W0_data = DATA_W'(ZERO_WORD);
        if (init_addr == LAST_ADDR) next_state = RUN;
`else
        next_state = RUN;
`endif
      end
      RUN: begin
        wr_ready     = 1'b1;
        rd_req_ready = grant;
        W0_en        = wr_valid;
        W0_addr      = wr_addr;
        W0_data      = wr_data;
      end
      default: next_state = BOOT;
    endcase
  end

  // Read mux and next round-robin pointer, from the one-hot handshake.
  always_comb begin
    rd_hs   = rd_req_valid & rd_req_ready;
    R0_addr = '0;
    rr_next = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_hs[i]) begin
        R0_addr = rd_req_addr[i*ADDR_W +: ADDR_W];
        rr_next = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign R0_en   = |rd_hs;
  assign wr_hs   = wr_valid & wr_ready;
  // The memory returns old data on a same-cycle collision, so capture the write.
  assign fwd_hit = R0_en && wr_hs && (R0_addr == wr_addr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      rd_resp_valid <= '0;
      fwd_q         <= 1'b0;
      wdata_q       <= '0;
    end else begin
      if (R0_en) rr_ptr <= rr_next;
      rd_resp_valid <= rd_hs;
      fwd_q         <= fwd_hit;
      if (fwd_hit) wdata_q <= wr_data;
    end
  end

  assign rd_resp_data = fwd_q ? wdata_q : R0_data;
  assign init_done    = (state == RUN);
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_1r1w_ctrl.sv
// Directed self-checking bench for mem_1r1w_ctrl with a behavioural 1R1W
// memory (old data on same-cycle collision). Follows MEM_1R1W_CTRL_INIT_EN.
module tb_mem_1r1w_ctrl;
  import mem_1r1w_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  rd_req_valid;
  logic [9:0]  rd_req_addr;
  logic [1:0]  rd_req_ready, rd_resp_valid;
  logic [63:0] rd_resp_data;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_ready, init_done;
  logic [4:0]  R0_addr, W0_addr;
  logic        R0_en, W0_en;
  logic [63:0] R0_data, W0_data;
  state_t      dbg_state;

  int checks = 0;
  int passed = 0;

  logic [63:0] mem [0:31];

  localparam logic [63:0] VAL_A = 64'hA5A5_0000_0000_0003;
  localparam logic [63:0] VAL_B = 64'h5A5A_0000_0000_0007;
  localparam logic [63:0] BEEF  = 64'h0000_0000_DEAD_BEEF;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

  mem_1r1w_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .init_done(init_done),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .dbg_state(dbg_state)
  );

  task automatic do_reset();
    reset_n = 1'b0; rd_req_valid = '0; rd_req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!init_done && n < 40) begin @(negedge clock); n++; end
    checks++;
    if (init_done !== 1'b1) $display("FAIL wait_run init_done=%b after %0d cycles, want 1", init_done, n);
    else passed++;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [63:0] d);
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rd_req_valid = 2'b01; rd_req_addr = {5'd0, 5'd5};
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
    repeat (2) @(negedge clock);
    checks++; if (dbg_state !== BOOT) $display("FAIL reset_state got %0d want %0d", dbg_state, BOOT); else passed++;
    checks++; if ({W0_en, R0_en, wr_ready, init_done} !== 4'b0000)
      $display("FAIL reset_enables got %b want 0000", {W0_en, R0_en, wr_ready, init_done}); else passed++;
    checks++; if ({rd_req_ready, rd_resp_valid} !== 4'b0000)
      $display("FAIL reset_rd got %b want 0000", {rd_req_ready, rd_resp_valid}); else passed++;
    reset_n = 1'b1;
    #1;
    checks++; if ({W0_en, rd_req_ready, wr_ready} !== 4'b0000)
      $display("FAIL boot_outputs got %b want 0000", {W0_en, rd_req_ready, wr_ready}); else passed++;
  endtask

`ifdef MEM_1R1W_CTRL_INIT_EN
  task automatic test_init();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      checks++;
      if (W0_en !== 1'b1 || W0_addr !== 5'(i - 1) || W0_data !== 64'd0)
        $display("FAIL init_write cycle %0d got en=%b addr=%0d data=%h want en=1 addr=%0d data=0",
                 i, W0_en, W0_addr, W0_data, i - 1);
      else passed++;
      checks++;
      if ({rd_req_ready, wr_ready, init_done} !== 4'b0000)
        $display("FAIL init_blocked cycle %0d got %b want 0000", i, {rd_req_ready, wr_ready, init_done});
      else passed++;
    end
    @(negedge clock);
    checks++; if (init_done !== 1'b1) $display("FAIL init_done_33 got %b want 1", init_done); else passed++;
    rd_req_valid = '0; wr_valid = 1'b0;
    for (int a = 0; a <= 32; a++) begin
      @(negedge clock);
      if (a > 0) begin
        checks++;
        if (rd_resp_valid !== 2'b01 || rd_resp_data !== 64'd0)
          $display("FAIL init_readback addr %0d got v=%b d=%h want v=01 d=0", a - 1, rd_resp_valid, rd_resp_data);
        else passed++;
      end
      if (a < 32) begin rd_req_valid = 2'b01; rd_req_addr = {5'd0, 5'(a)}; end
      else rd_req_valid = '0;
    end
  endtask
`else
  task automatic test_init();
    @(negedge clock);
    checks++; if (init_done !== 1'b1) $display("FAIL init_done_1 got %b want 1", init_done); else passed++;
    checks++; if (rd_req_ready !== 2'b01 || R0_en !== 1'b1 || R0_addr !== 5'd5)
      $display("FAIL first_read got rdy=%b en=%b addr=%0d want 01 1 5", rd_req_ready, R0_en, R0_addr); else passed++;
    rd_req_valid = '0; wr_valid = 1'b0;
  endtask
`endif

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [63:0] exp_d;
    do_reset();
    wait_run();
    write_word(5'd3, VAL_A);
    write_word(5'd7, VAL_B);
    rd_req_valid = 2'b11; rd_req_addr = {5'd7, 5'd3};
    #1;
    checks++; if (rd_req_ready !== 2'b01) $display("FAIL rr_grant 0 got %b want 01", rd_req_ready); else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      exp_g = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = ((k - 1) % 2 == 0) ? VAL_A : VAL_B;
      checks++;
      if (rd_resp_valid !== exp_g || rd_resp_data !== exp_d)
        $display("FAIL rr_resp %0d got v=%b d=%h want v=%b d=%h", k - 1, rd_resp_valid, rd_resp_data, exp_g, exp_d);
      else passed++;
      if (k < 4) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (rd_req_ready !== exp_g) $display("FAIL rr_grant %0d got %b want %b", k, rd_req_ready, exp_g);
        else passed++;
      end else rd_req_valid = '0;
    end
  endtask

  task automatic test_forwarding();
    write_word(5'd9, 64'h1111);
    rd_req_valid = 2'b10; rd_req_addr = {5'd9, 5'd0};
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = BEEF;
    #1;
    checks++; if (rd_req_ready !== 2'b10 || wr_ready !== 1'b1)
      $display("FAIL fwd_handshake got rdy=%b wr_ready=%b want 10 1", rd_req_ready, wr_ready); else passed++;
    @(negedge clock);
    checks++; if (rd_resp_valid !== 2'b10 || rd_resp_data !== BEEF)
      $display("FAIL fwd_data got v=%b d=%h want v=10 d=%h", rd_resp_valid, rd_resp_data, BEEF); else passed++;
    wr_valid = 1'b0;
    @(negedge clock);
    checks++; if (rd_resp_valid !== 2'b10 || rd_resp_data !== BEEF)
      $display("FAIL read_after_write got v=%b d=%h want v=10 d=%h", rd_resp_valid, rd_resp_data, BEEF); else passed++;
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 64'h2222;
    @(negedge clock);
    checks++; if (rd_resp_data !== BEEF)
      $display("FAIL no_fwd_diff_addr got d=%h want d=%h", rd_resp_data, BEEF); else passed++;
    wr_valid = 1'b0; rd_req_valid = '0;
    @(negedge clock);
    checks++; if (rd_resp_valid !== 2'b00) $display("FAIL idle_resp got %b want 00", rd_resp_valid); else passed++;
  endtask

  task automatic test_single();
    rd_req_valid = 2'b10; rd_req_addr = {5'd7, 5'd3};
    #1;
    checks++; if (rd_req_ready !== 2'b10) $display("FAIL single_grant 0 got %b want 10", rd_req_ready); else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++;
      if (rd_resp_valid !== 2'b10 || rd_resp_data !== VAL_B)
        $display("FAIL single_resp %0d got v=%b d=%h want v=10 d=%h", k, rd_resp_valid, rd_resp_data, VAL_B);
      else passed++;
      if (k < 4) begin
        checks++;
        if (rd_req_ready !== 2'b10) $display("FAIL single_grant %0d got %b want 10", k, rd_req_ready);
        else passed++;
      end else rd_req_valid = '0;
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clock);
    rd_req_valid = 2'b01; rd_req_addr = {5'd0, 5'd3};
    @(negedge clock);
    checks++; if (rd_resp_valid !== 2'b01) $display("FAIL mid_inflight got %b want 01", rd_resp_valid); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if (rd_resp_valid !== 2'b00 || R0_en !== 1'b0 || init_done !== 1'b0)
      $display("FAIL mid_reset got v=%b en=%b done=%b want 00 0 0", rd_resp_valid, R0_en, init_done); else passed++;
    rd_req_valid = '0;
    @(negedge clock);
    reset_n = 1'b1;
`ifdef MEM_1R1W_CTRL_INIT_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (W0_en !== 1'b1 || W0_addr !== 5'(i))
        $display("FAIL reinit_addr %0d got en=%b addr=%0d want en=1 addr=%0d", i, W0_en, W0_addr, i);
      else passed++;
    end
`else
    @(negedge clock);
    checks++; if (init_done !== 1'b1) $display("FAIL rerun_done got %b want 1", init_done); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_round_robin();
    test_forwarding();
    test_single();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
